td4x_core: RTL and testbench
============================

// Module: td4x_core
// PURPOSE
//   Parametrised TD4-class accumulator CPU: two registers (A, B), carry flag, output port, input port.
//   Generalises data width and program depth; adds a loadable program store, run/halt control and a retire strobe.
//   Top-level CPU of the board design; switches drive in_port, LEDs are driven from out_port.
// PARAMETERS
//   DATA_W  4  width of A, B, in_port, out_port and the immediate field (>=4)
//   PC_W    4  program counter width; program depth = 2**PC_W words (PC_W <= DATA_W)
//   INSN_W  4+DATA_W  instruction width {op[3:0], imm[DATA_W-1:0]} (derived, not overridable)
// PORTS
//   clock      in   1       single clock, rising edge
//   reset      in   1       synchronous, active-high
//   run        in   1       1: execute one instruction per clock; 0: halted
//   step       in   1       single-step pulse (TD4X_STEP_EN only; ignored otherwise)
//   in_port    in   DATA_W  input operand for IN A / IN B
//   out_port   out  DATA_W  registered output port
//   prog_we    in   1       program store write enable
//   prog_addr  in   PC_W    program store write address
//   prog_data  in   INSN_W  program store write data
//   pc         out  PC_W    current instruction pointer (debug)
//   retire     out  1       1-cycle pulse: an instruction completed on this edge
// BEHAVIOUR
//   Reset: pc=0, A=0, B=0, C=0, out_port=0, retire=0. Program store is NOT cleared; reset mid-run wins over execution.
//   Execute cycle (exec = run, or step per CONFIGURATION): fetch mem[pc] combinationally, all state updates at the edge; latency 1.
//   ALU: {c_out, res} = src + imm, DATA_W+1 bits; res wraps mod 2**DATA_W; src in {A, B, in_port, 0}.
//   Opcodes (op): 0000 ADD A,imm  0001 MOV A,B  0010 IN A  0011 MOV A,imm  0100 MOV B,A  0101 ADD B,imm
//     0110 IN B  0111 MOV B,imm  1001 OUT B  1011 OUT imm  1110 JNC imm  1111 JMP imm.
//   Every defined opcode sets C <= c_out (MOV/IN/OUT/JMP forms add imm, so C may be set by them too).
//   Undefined opcodes 1000,1010,1100,1101: NOP — pc+1, A/B/out/C unchanged, retire still pulses.
//   JMP: pc <= res[PC_W-1:0]. JNC: jump if C==0 (C as held before this instruction), else pc+1. Others: pc+1.
//   pc wraps 2**PC_W-1 -> 0. Jump target truncates high bits of res when PC_W < DATA_W.
//   Halted (exec=0): all architectural state and out_port hold; retire=0.
//   Program write: mem[prog_addr] <= prog_data at the edge, accepted while running or halted.
//   Write to the address being fetched in the same cycle: the executed instruction is the OLD content.
//   retire <= exec (registered), so it is high the cycle after each executed edge.
// CONFIGURATION
//   TD4X_STEP_EN defined: exec = run | step_rise, step_rise = step & ~step_q (step_q registered, reset 0);
//     one instruction per step rising edge while run=0; holding step high executes only once.
//   TD4X_STEP_EN undefined: exec = run; step ignored; no step_q register.
// STRUCTURE
//   td4x_pkg: opcode localparams (OP_ADD_A ... OP_JMP), source-select encoding, INSN_W function.
//   Sub-module td4x_progmem: 2**PC_W x INSN_W array, sync write port, async read port; no reset.
//   Decode, ALU and register update stay in td4x_core.
// TESTING (DATA_W=4, PC_W=4 unless stated)
//   Reset, load {MOV A,1100; MOV A,0110; MOV B,0011; MOV B,1001}, run=1 -> after 4 edges A=6, B=9, pc=4, C=0.
//   MOV A,1111; ADD A,0001 -> A=0, C=1; next JNC 0x0 falls through (pc+1); after ADD A,0 (C=0) JNC 0x0 sets pc=0.
//   in_port=0101; IN B,0011; OUT B -> out_port=1000 one edge after OUT; OUT imm 1010 -> out_port=1010.
//   pc=15 executing NOP (op 1000) -> pc=0, A/B/C unchanged, retire pulses once.
//   run=0 for 5 cycles mid-program -> pc/A/B/out_port frozen, retire=0; reset asserted while run=1 -> all cleared next edge.
//   DATA_W=8, PC_W=6: JMP 0xC5 -> pc=0x05; ADD A,0xFF with A=0x01 -> A=0x00, C=1.
//   TD4X_STEP_EN: run=0, step high 3 cycles -> exactly one instruction retires; same build with macro off -> none.

Source files
------------

// File: rtl/td4x_pkg.sv
// td4x_pkg: shared definitions for the TD4-class accumulator CPU.
//   - opcode encodings (upper nibble of every instruction word)
//   - ALU source-select encoding
//   - td4x_insn_w(): instruction width derived from the data width
package td4x_pkg;

    // Opcode encodings; any other value executes as a NOP.
    localparam logic [3:0] OP_ADD_A  = 4'b0000;  // A <= A + imm
    localparam logic [3:0] OP_MOV_AB = 4'b0001;  // A <= B + imm
    localparam logic [3:0] OP_IN_A   = 4'b0010;  // A <= in_port + imm
    localparam logic [3:0] OP_MOV_AI = 4'b0011;  // A <= imm
    localparam logic [3:0] OP_MOV_BA = 4'b0100;  // B <= A + imm
    localparam logic [3:0] OP_ADD_B  = 4'b0101;  // B <= B + imm
    localparam logic [3:0] OP_IN_B   = 4'b0110;  // B <= in_port + imm
    localparam logic [3:0] OP_MOV_BI = 4'b0111;  // B <= imm
    localparam logic [3:0] OP_OUT_B  = 4'b1001;  // out <= B + imm
    localparam logic [3:0] OP_OUT_I  = 4'b1011;  // out <= imm
    localparam logic [3:0] OP_JNC    = 4'b1110;  // pc <= imm when C was clear
    localparam logic [3:0] OP_JMP    = 4'b1111;  // pc <= imm

    // First ALU operand; the second operand is always the immediate.
    typedef enum logic [1:0] {
        SRC_A    = 2'd0,
        SRC_B    = 2'd1,
        SRC_IN   = 2'd2,
        SRC_ZERO = 2'd3
    } src_sel_e;

    // Instruction word = {op[3:0], imm[data_w-1:0]}.
    function automatic int td4x_insn_w(input int data_w);
        return data_w + 32'sd4;
    endfunction

endpackage

// File: rtl/td4x_progmem.sv
// td4x_progmem: program store, 2**PC_W words of INSN_W bits.
//   Synchronous write port, asynchronous read port, contents are not reset.
//   A write and a read of the same address in one cycle return the old word.
// Ports:
//   clock      in   rising-edge clock
//   prog_we    in   write enable
//   prog_addr  in   write address
//   prog_data  in   write data
//   rd_addr    in   read address (instruction pointer)
//   rd_data    out  word at rd_addr (combinational)
module td4x_progmem #(
    parameter int PC_W   = 4,
    parameter int INSN_W = 8
) (
    input  logic              clock,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [INSN_W-1:0] prog_data,
    input  logic [PC_W-1:0]   rd_addr,
    output logic [INSN_W-1:0] rd_data
);

    logic [INSN_W-1:0] mem_r [2**PC_W];

    // Store write port; deliberately has no reset so a program survives CPU reset.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-class accumulator CPU.
//   Registers A, B, carry C, output port and a loadable program store.
//   One instruction executes per exec clock; fetch is combinational from
//   the store, all architectural state updates at the rising edge.
// Optional feature macro: TD4X_STEP_EN
//   defined   : exec = run | rising edge of step (single-step while halted)
//   undefined : exec = run, step is ignored
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset (program store kept)
//   run        in   1 = execute every clock, 0 = halted
//   step       in   single-step request (TD4X_STEP_EN only)
//   in_port    in   operand for IN A / IN B
//   out_port   out  registered output port
//   prog_we    in   program store write enable
//   prog_addr  in   program store write address
//   prog_data  in   program store write data
//   pc         out  current instruction pointer
//   retire     out  high the cycle after each executed instruction
module td4x_core
    import td4x_pkg::*;
#(
    parameter int  DATA_W = 4,
    parameter int  PC_W   = 4,
    localparam int INSN_W = td4x_insn_w(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [INSN_W-1:0] prog_data,
    output logic [PC_W-1:0]   pc,
    output logic              retire
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]   pc_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              c_r;
    logic [DATA_W-1:0] out_r;
    logic              retire_r;

    logic [PC_W-1:0]   pc_n_s;
    logic [DATA_W-1:0] a_n_s;
    logic [DATA_W-1:0] b_n_s;
    logic              c_n_s;
    logic [DATA_W-1:0] out_n_s;

    logic [INSN_W-1:0] insn_s;
    logic [3:0]        op_s;
    logic [DATA_W-1:0] imm_s;
    src_sel_e          src_sel_s;
    logic [DATA_W-1:0] src_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] res_s;
    logic              cout_s;
    logic [PC_W-1:0]   pc_inc_s;
    logic              exec_s;

    td4x_progmem #(
        .PC_W   (PC_W),
        .INSN_W (INSN_W)
    ) u_progmem (
        .clock     (clock),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .rd_addr   (pc_r),
        .rd_data   (insn_s)
    );

`ifdef TD4X_STEP_EN
    logic step_q_r;

    // Previous step level, used to detect a rising edge of the step request.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_q_r <= 1'b0;
        end else begin
            step_q_r <= step;
        end
    end

    // Holding step high yields one execute cycle only.
    assign exec_s = run | (step & ~step_q_r);
`else
    logic unused_step_s;
    assign unused_step_s = step;
    assign exec_s        = run;
`endif

    assign op_s  = insn_s[INSN_W-1 -: 4];
    assign imm_s = insn_s[DATA_W-1:0];

    // Decode the first ALU operand from the opcode.
    always_comb begin
        src_sel_s = SRC_ZERO;
        case (op_s)
            OP_ADD_A:  src_sel_s = SRC_A;
            OP_MOV_AB: src_sel_s = SRC_B;
            OP_IN_A:   src_sel_s = SRC_IN;
            OP_MOV_BA: src_sel_s = SRC_A;
            OP_ADD_B:  src_sel_s = SRC_B;
            OP_IN_B:   src_sel_s = SRC_IN;
            OP_OUT_B:  src_sel_s = SRC_B;
            default:   src_sel_s = SRC_ZERO;
        endcase
    end

    // Operand multiplexer.
    always_comb begin
        src_s = {DATA_W{1'b0}};
        case (src_sel_s)
            SRC_A:   src_s = a_r;
            SRC_B:   src_s = b_r;
            SRC_IN:  src_s = in_port;
            default: src_s = {DATA_W{1'b0}};
        endcase
    end

    // Single adder shared by every instruction; the carry out feeds C.
    assign sum_s    = {1'b0, src_s} + {1'b0, imm_s};
    assign res_s    = sum_s[DATA_W-1:0];
    assign cout_s   = sum_s[DATA_W];
    assign pc_inc_s = pc_r + PC_ONE;

    // Next architectural state; undefined opcodes only advance pc.
    always_comb begin
        pc_n_s  = pc_r;
        a_n_s   = a_r;
        b_n_s   = b_r;
        c_n_s   = c_r;
        out_n_s = out_r;
        if (exec_s) begin
            pc_n_s = pc_inc_s;
            case (op_s)
                OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: begin
                    a_n_s = res_s;
                    c_n_s = cout_s;
                end
                OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: begin
                    b_n_s = res_s;
                    c_n_s = cout_s;
                end
                OP_OUT_B, OP_OUT_I: begin
                    out_n_s = res_s;
                    c_n_s   = cout_s;
                end
                OP_JNC: begin
                    // Branch decision uses C as held before this instruction.
                    c_n_s = cout_s;
                    if (!c_r) begin
                        pc_n_s = res_s[PC_W-1:0];
                    end else begin
                        pc_n_s = pc_inc_s;
                    end
                end
                OP_JMP: begin
                    c_n_s  = cout_s;
                    pc_n_s = res_s[PC_W-1:0];
                end
                default: begin
                    pc_n_s = pc_inc_s;
                end
            endcase
        end else begin
            pc_n_s = pc_r;
        end
    end

    // Architectural state registers; reset overrides execution.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r     <= {PC_W{1'b0}};
            a_r      <= {DATA_W{1'b0}};
            b_r      <= {DATA_W{1'b0}};
            c_r      <= 1'b0;
            out_r    <= {DATA_W{1'b0}};
            retire_r <= 1'b0;
        end else begin
            pc_r     <= pc_n_s;
            a_r      <= a_n_s;
            b_r      <= b_n_s;
            c_r      <= c_n_s;
            out_r    <= out_n_s;
            retire_r <= exec_s;
        end
    end

    assign out_port = out_r;
    assign pc       = pc_r;
    assign retire   = retire_r;

endmodule

// File: tb/tb_td4x_core.sv
// Self-checking bench for td4x_core: directed scenarios plus a randomized
// run compared against a behavioural model of the instruction set.
module tb_td4x_core;

    logic       clock = 1'b0;
    logic       reset, run, step, prog_we, retire;
    logic [3:0] in_port, out_port, prog_addr, pc;
    logic [7:0] prog_data;

    logic        w_reset, w_run, w_prog_we, w_retire;
    logic [7:0]  w_in, w_out;
    logic [5:0]  w_prog_addr, w_pc;
    logic [11:0] w_prog_data;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_pc, m_a, m_b, m_c, m_out, m_ret, m_stepq;
    int m_mem [16];

    always #5 clock = ~clock;

    td4x_core dut (
        .clock(clock), .reset(reset), .run(run), .step(step),
        .in_port(in_port), .out_port(out_port), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .pc(pc), .retire(retire)
    );

    td4x_core #(.DATA_W(8), .PC_W(6)) dut_w (
        .clock(clock), .reset(w_reset), .run(w_run), .step(1'b0),
        .in_port(w_in), .out_port(w_out), .prog_we(w_prog_we),
        .prog_addr(w_prog_addr), .prog_data(w_prog_data), .pc(w_pc), .retire(w_retire)
    );

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int ex, op, imm, src, sum, res, cout;
        ex = (run === 1'b1) ? 1 : 0;
`ifdef TD4X_STEP_EN
        if (step === 1'b1 && m_stepq == 0) ex = 1;
        m_stepq = (step === 1'b1) ? 1 : 0;
`endif
        if (reset === 1'b1) begin
            m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_ret = 0; m_stepq = 0;
        end else begin
            if (ex != 0) begin
                op  = m_mem[m_pc] / 16;
                imm = m_mem[m_pc] % 16;
                case (op)
                    0, 4:    src = m_a;
                    1, 5, 9: src = m_b;
                    2, 6:    src = int'(in_port);
                    default: src = 0;
                endcase
                sum  = src + imm;
                res  = sum % 16;
                cout = (sum > 15) ? 1 : 0;
                if (op inside {8, 10, 12, 13}) begin
                    m_pc = (m_pc + 1) % 16;
                end else begin
                    if (op < 4) m_a = res;
                    else if (op < 8) m_b = res;
                    else if (op == 9 || op == 11) m_out = res;
                    if (op == 15 || (op == 14 && m_c == 0)) m_pc = res;
                    else m_pc = (m_pc + 1) % 16;
                    m_c = cout;
                end
            end
            m_ret = ex;
        end
        if (prog_we === 1'b1) m_mem[prog_addr] = int'(prog_data);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; prog_we = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] words [$]);
        run = 1'b0;
        foreach (words[i]) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = words[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        run = 1'b1;
        tick();
        do_reset();
        n_cmp++;
        if (pc !== 4'h0 || out_port !== 4'h0 || retire !== 1'b0) begin
            n_err++;
            $display("FAIL reset: pc=%h out=%h retire=%b, required 0/0/0", pc, out_port, retire);
        end
        n_cmp++;
        if (dut.a_r !== 4'h0 || dut.b_r !== 4'h0 || dut.c_r !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs: a=%h b=%h c=%b, required 0/0/0", dut.a_r, dut.b_r, dut.c_r);
        end
    endtask

    task automatic test_mov();
        load('{8'h3C, 8'h36, 8'h73, 8'h79});
        do_reset();
        run = 1'b1;
        repeat (4) tick();
        run = 1'b0;
        n_cmp++;
        if (dut.a_r !== 4'h6 || dut.b_r !== 4'h9 || pc !== 4'h4 || dut.c_r !== 1'b0) begin
            n_err++;
            $display("FAIL mov: a=%h b=%h pc=%h c=%b, required 6/9/4/0", dut.a_r, dut.b_r, pc, dut.c_r);
        end
    endtask

    task automatic test_carry_jnc();
        do_reset();
        load('{8'h3F, 8'h01, 8'hE0, 8'h00, 8'hE0});
        run = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (dut.a_r !== 4'h0 || dut.c_r !== 1'b1) begin
            n_err++;
            $display("FAIL add_carry: a=%h c=%b, required 0/1", dut.a_r, dut.c_r);
        end
        tick();
        n_cmp++;
        if (pc !== 4'h3) begin
            n_err++;
            $display("FAIL jnc_fall: pc=%h, required 3", pc);
        end
        repeat (2) tick();
        run = 1'b0;
        n_cmp++;
        if (pc !== 4'h0) begin
            n_err++;
            $display("FAIL jnc_taken: pc=%h, required 0", pc);
        end
    endtask

    task automatic test_io();
        do_reset();
        load('{8'h63, 8'h90, 8'hBA});
        in_port = 4'b0101;
        run = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (out_port !== 4'b1000) begin
            n_err++;
            $display("FAIL out_b: out=%b, required 1000", out_port);
        end
        tick();
        run = 1'b0;
        n_cmp++;
        if (out_port !== 4'b1010) begin
            n_err++;
            $display("FAIL out_imm: out=%b, required 1010", out_port);
        end
    endtask

    task automatic test_nop_wrap();
        int rcount;
        do_reset();
        load('{8'h35, 8'h7A, 8'hFF});
        prog_we = 1'b1; prog_addr = 4'hF; prog_data = 8'h80;
        tick();
        prog_we = 1'b0;
        run = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (pc !== 4'hF) begin
            n_err++;
            $display("FAIL jmp15: pc=%h, required f", pc);
        end
        tick();
        run = 1'b0;
        n_cmp++;
        if (pc !== 4'h0 || dut.a_r !== 4'h5 || dut.b_r !== 4'hA || dut.c_r !== 1'b0 || retire !== 1'b1) begin
            n_err++;
            $display("FAIL nop_wrap: pc=%h a=%h b=%h c=%b ret=%b, required 0/5/a/0/1",
                     pc, dut.a_r, dut.b_r, dut.c_r, retire);
        end
        rcount = 0;
        repeat (2) begin
            tick();
            if (retire === 1'b1) rcount++;
        end
        n_cmp++;
        if (rcount != 0) begin
            n_err++;
            $display("FAIL retire_once: extra pulses=%0d, required 0", rcount);
        end
    endtask

    task automatic test_halt_reset();
        logic [3:0] pc0, out0;
        do_reset();
        load('{8'h33, 8'h45, 8'h90, 8'h51, 8'h90, 8'hF0});
        run = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        tick();
        pc0 = pc; out0 = out_port;
        repeat (5) begin
            tick();
            n_cmp++;
            if (pc !== pc0 || out_port !== out0 || retire !== 1'b0 || pc !== 4'(m_pc) || out_port !== 4'(m_out)) begin
                n_err++;
                $display("FAIL halt: pc=%h out=%h ret=%b, required %h/%h/0", pc, out_port, retire, m_pc, m_out);
            end
        end
        run = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0;
        n_cmp++;
        if (pc !== 4'h0 || out_port !== 4'h0 || retire !== 1'b0 || dut.a_r !== 4'h0 ||
            dut.b_r !== 4'h0 || dut.c_r !== 1'b0) begin
            n_err++;
            $display("FAIL reset_run: pc=%h out=%h ret=%b a=%h b=%h c=%b, required all 0",
                     pc, out_port, retire, dut.a_r, dut.b_r, dut.c_r);
        end
    endtask

    task automatic test_random();
        logic [7:0] prog [$];
        do_reset();
        for (int i = 0; i < 16; i++) prog.push_back(8'($urandom));
        load(prog);
        for (int cyc = 0; cyc < 400; cyc++) begin
            run     = ($urandom_range(3, 0) != 0);
            in_port = 4'($urandom);
            prog_we = ($urandom_range(5, 0) == 0);
            prog_addr = ($urandom_range(1, 0) == 0) ? 4'(m_pc) : 4'($urandom);
            prog_data = 8'($urandom);
            tick();
            n_cmp++;
            if (pc !== 4'(m_pc) || out_port !== 4'(m_out) || retire !== 1'(m_ret) ||
                dut.a_r !== 4'(m_a) || dut.b_r !== 4'(m_b) || dut.c_r !== 1'(m_c)) begin
                n_err++;
                $display("FAIL random[%0d]: pc=%h out=%h ret=%b a=%h b=%h c=%b, required %h/%h/%0d/%h/%h/%0d",
                         cyc, pc, out_port, retire, dut.a_r, dut.b_r, dut.c_r,
                         m_pc, m_out, m_ret, m_a, m_b, m_c);
            end
        end
        run = 1'b0; prog_we = 1'b0;
    endtask

    task automatic test_wide();
        logic [11:0] words [3];
        words = '{12'hFC5, 12'h301, 12'h0FF};
        w_reset = 1'b1; w_run = 1'b0; w_prog_we = 1'b0; w_in = 8'h00;
        tick();
        w_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_prog_we = 1'b1;
            w_prog_addr = (i == 0) ? 6'h00 : 6'(i + 4);
            w_prog_data = words[i];
            tick();
        end
        w_prog_we = 1'b0;
        w_run = 1'b1;
        tick();
        n_cmp++;
        if (w_pc !== 6'h05) begin
            n_err++;
            $display("FAIL wide_jmp: pc=%h, required 05", w_pc);
        end
        repeat (2) tick();
        w_run = 1'b0;
        n_cmp++;
        if (dut_w.a_r !== 8'h00 || dut_w.c_r !== 1'b1) begin
            n_err++;
            $display("FAIL wide_add: a=%h c=%b, required 00/1", dut_w.a_r, dut_w.c_r);
        end
    endtask

    task automatic test_step();
        int rcount, exp_n;
`ifdef TD4X_STEP_EN
        exp_n = 1;
`else
        exp_n = 0;
`endif
        do_reset();
        load('{8'h31, 8'h32, 8'h33});
        rcount = 0;
        step = 1'b1;
        repeat (3) begin
            tick();
            if (retire === 1'b1) rcount++;
        end
        step = 1'b0;
        repeat (2) begin
            tick();
            if (retire === 1'b1) rcount++;
        end
        n_cmp++;
        if (rcount != exp_n || pc !== 4'(exp_n)) begin
            n_err++;
            $display("FAIL step: retired=%0d pc=%h, required %0d/%0d", rcount, pc, exp_n, exp_n);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; in_port = 4'h0;
        prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
        w_reset = 1'b1; w_run = 1'b0; w_in = 8'h00;
        w_prog_we = 1'b0; w_prog_addr = 6'h00; w_prog_data = 12'h000;
        m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_ret = 0; m_stepq = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        // start from a known program image so model and store agree
        load('{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
               8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80});
        test_reset();
        test_mov();
        test_carry_jnc();
        test_io();
        test_nop_wrap();
        test_halt_reset();
        test_random();
        test_wide();
        test_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
